gcd_req_arbiter: RTL
====================

Name: gcd_req_arbiter

Overview:
- Shares one GCD datapath/controller pair among N_REQ requesters.
- Arbitrates round-robin and latches the winner's operands. Issues a single-cycle start to the GCD unit and waits for its done.
- Returns the result to the winner with a one-cycle valid and enforces a watchdog timeout.
- Zero operands bypass the GCD unit; the arbiter returns the result itself.

Parameters:
N_REQ, 4, number of requesters (>=2)
WIDTH, 16, operand/result width in bits
TIMEOUT, 1023, max cycles in WAIT before abort (>=1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  N_REQ  per-requester request level; requester i holds req[i] and its operands until gnt[i]
op_a  input  N_REQ*WIDTH  flattened operand A; requester i at bits [i*WIDTH +: WIDTH]
op_b  input  N_REQ*WIDTH  flattened operand B, same packing
gnt  output  N_REQ  one-hot accept pulse, one cycle
rsp_valid  output  N_REQ  one-hot result pulse, one cycle
rsp_data  output  WIDTH  result; meaningful only while any rsp_valid bit is high
rsp_err  output  1  timeout flag, qualified by rsp_valid
busy  output  1  high whenever state != IDLE
gcd_start  output  1  one-cycle start to GCD unit
gcd_a  output  WIDTH  operand A to GCD unit; held stable from ISSUE through WAIT
gcd_b  output  WIDTH  operand B to GCD unit; same hold rule
gcd_done  input  1  GCD unit completion; sampled only in WAIT
gcd_result  input  WIDTH  GCD unit result; valid with gcd_done

Behaviour:
- Reset (async, rst_n=0): state=IDLE; gnt, rsp_valid, rsp_err, gcd_start, busy all 0; rsp_data, gcd_a, gcd_b, timer all 0; rr pointer=N_REQ-1, so requester 0 wins first.
- All outputs are registered.
- FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req != 0 at the clock edge, select the first set bit searching from pointer+1 upward with wraparound.
  - Latch index and both operands, set gnt[idx]=1 and go to ISSUE.
  - If req == 0, stay in IDLE.
- ISSUE (exactly one cycle, gnt[idx] high):
  - If the latched A==0 or B==0, do not start the GCD unit. Go to RESP with result = A|B (gcd(0,x)=x; gcd(0,0)=0) and rsp_err=0.
  - Otherwise assert gcd_start for this cycle only, drive gcd_a/gcd_b, clear the timer and go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - If gcd_done=1: capture gcd_result, set rsp_err=0 and go to RESP.
  - Else if timer == TIMEOUT-1: set result=0, rsp_err=1 and go to RESP.
  - If gcd_done and the timeout land in the same cycle, done wins.
- RESP (one cycle): rsp_valid[idx]=1 with rsp_data and rsp_err; pointer<=idx; go to IDLE.
- Handshake rules:
  - Requester deasserts req[i] the cycle after gnt[i].
  - A req still high on return to IDLE counts as a new request.
  - Dropping req before gnt withdraws the request with no side effect.
  - Operands are not sampled after the grant edge.
- gcd_done outside WAIT is ignored. gcd_start never asserts outside ISSUE.
- Latency (req high in IDLE at edge 0):
  - gnt and gcd_start are high in cycle 1.
  - WAIT runs from cycle 2.
  - rsp_valid is high the cycle after gcd_done is seen.
  - Bypass path: rsp_valid in cycle 2.
  - Back-to-back throughput: one new grant per (GCD latency + 3) cycles.
- Fairness: a requester that holds req continuously is served within N_REQ grants.
- Reset mid-operation returns to IDLE immediately. The in-flight result is discarded and no rsp_valid is emitted. The GCD unit is re-initialised by its next gcd_start.
- Widths: timer is clog2(TIMEOUT+1) bits. No arithmetic is done on operands.

Test Plan:
- Single req[2] with A=48, B=18; GCD model asserts done with 6 after 5 cycles. Required: gnt=4'b0100 in cycle 1, gcd_start one cycle with gcd_a=48/gcd_b=18, then rsp_valid=4'b0100, rsp_data=6, rsp_err=0.
- req=4'b1111 held continuously, each request re-asserted after its response. Required: grant order 0,1,2,3,0, with no requester granted twice in any window of 4 grants.
- Zero bypass with req[1], A=0, B=35. Required: no gcd_start, rsp_valid[1] in cycle 2, rsp_data=35. Also A=0, B=0 -> rsp_data=0.
- Timeout with TIMEOUT=8 and a GCD model that never asserts done. Required: rsp_err=1, rsp_data=0, rsp_valid to the owner exactly 8 cycles after WAIT entry, then IDLE. Also gcd_done on the final WAIT cycle -> rsp_err=0.
- rst_n pulsed low in WAIT. Required: all outputs 0 asynchronously, no rsp_valid afterwards, pointer reset, so the next simultaneous req=4'b1010 grants requester 1.
- Spurious gcd_done=1 in IDLE/RESP, and req[3] dropped before grant. Required: no state change and no gnt[3].

Source files
------------

// File: rtl/gcd_req_arbiter.sv
// gcd_req_arbiter: round-robin sharing of one GCD unit among N_REQ requesters, with zero-operand bypass and a watchdog
module gcd_req_arbiter #(
   parameter int N_REQ   = 4,
   parameter int WIDTH   = 16,
   parameter int TIMEOUT = 1023
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] op_a,
   input  logic [N_REQ*WIDTH-1:0] op_b,
   output logic [N_REQ-1:0]       gnt,
   output logic [N_REQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]       rsp_data,
   output logic                   rsp_err,
   output logic                   busy,
   output logic                   gcd_start,
   output logic [WIDTH-1:0]       gcd_a,
   output logic [WIDTH-1:0]       gcd_b,
   input  logic                   gcd_done,
   input  logic [WIDTH-1:0]       gcd_result
);
   localparam int IW = $clog2(N_REQ);
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d, idx_q, idx_d, sel;
   logic [TW-1:0] timer_q, timer_d;
   logic [N_REQ-1:0] gnt_q, gnt_d, rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d, gcd_a_q, gcd_a_d, gcd_b_q, gcd_b_d, sel_a, sel_b;
   logic rsp_err_q, rsp_err_d, busy_q, busy_d, gcd_start_q, gcd_start_d, hi;
   always_comb begin
      hi = 1'b0;
      for (int i = 0; i < N_REQ; i++) hi |= req[i] && i > int'(ptr_q);
      sel = '0;
      sel_a = '0;
      sel_b = '0;
      // Downward scan: lowest requester above the pointer, else lowest overall
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i] && (!hi || i > int'(ptr_q))) begin
            sel = IW'(i);
            sel_a = op_a[i*WIDTH +: WIDTH];
            sel_b = op_b[i*WIDTH +: WIDTH];
         end
      end
   end
   always_comb begin
      state_d = state_q;
      ptr_d = ptr_q;
      idx_d = idx_q;
      timer_d = timer_q;
      gnt_d = '0;
      rsp_data_d = '0;
      rsp_err_d = 1'b0;
      gcd_start_d = 1'b0;
      gcd_a_d = gcd_a_q;
      gcd_b_d = gcd_b_q;
      case (state_q)
         IDLE: if (|req) begin
            state_d = ISSUE;
            idx_d = sel;
            gcd_a_d = sel_a;
            gcd_b_d = sel_b;
            gnt_d = N_REQ'(1) << sel;
            gcd_start_d = |sel_a && |sel_b;
         end
         ISSUE: begin
            timer_d = '0;
            state_d = gcd_start_q ? WAIT : RESP;
            rsp_data_d = gcd_start_q ? '0 : gcd_a_q | gcd_b_q;
         end
         WAIT: begin
            timer_d = timer_q + TW'(1);
            if (gcd_done) begin
               state_d = RESP;
               rsp_data_d = gcd_result;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               state_d = RESP;
               rsp_err_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            ptr_d = idx_q;
         end
      endcase
      rsp_valid_d = (state_d == RESP) ? N_REQ'(1) << idx_d : '0;
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q <= IW'(N_REQ - 1);
         idx_q <= '0;
         timer_q <= '0;
         gnt_q <= '0;
         rsp_valid_q <= '0;
         rsp_data_q <= '0;
         rsp_err_q <= 1'b0;
         busy_q <= 1'b0;
         gcd_start_q <= 1'b0;
         gcd_a_q <= '0;
         gcd_b_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         idx_q <= idx_d;
         timer_q <= timer_d;
         gnt_q <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q <= rsp_err_d;
         busy_q <= busy_d;
         gcd_start_q <= gcd_start_d;
         gcd_a_q <= gcd_a_d;
         gcd_b_q <= gcd_b_d;
      end
   end
   assign gnt = gnt_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data = rsp_data_q;
   assign rsp_err = rsp_err_q;
   assign busy = busy_q;
   assign gcd_start = gcd_start_q;
   assign gcd_a = gcd_a_q;
   assign gcd_b = gcd_b_q;
endmodule
